// File: rtl/dataflow_deadlock_tracer_if.sv
// Stall-monitor bundle between a dataflow region (master side) and the deadlock tracer (slave side).
//  enable, clear          : monitor control
//  blocked[N_PROC]        : per-process stalled flags
//  wait_on[N_PROC*N_PROC] : bit i*N_PROC+j set when process i waits on process j
//  deadlock, cycle_mask, origin, state : tracer report and debug state
interface dataflow_deadlock_tracer_if #(
    parameter int unsigned N_PROC = 3
);
    localparam int unsigned ID_W = (N_PROC > 1) ? $clog2(N_PROC) : 1;

    logic                       enable;
    logic                       clear;
    logic [N_PROC-1:0]          blocked;
    logic [N_PROC*N_PROC-1:0]   wait_on;
    logic                       deadlock;
    logic [N_PROC-1:0]          cycle_mask;
    logic [ID_W-1:0]            origin;
    logic [2:0]                 state;

    modport master (
        output enable, clear, blocked, wait_on,
        input  deadlock, cycle_mask, origin, state
    );

    modport slave (
        input  enable, clear, blocked, wait_on,
        output deadlock, cycle_mask, origin, state
    );
endinterface

// File: rtl/dataflow_deadlock_tracer.sv
// Dataflow deadlock tracer: after a stall pattern stays unchanged for STALL_CYCLES cycles it walks
// the snapshotted wait-for graph one hop per cycle and reports the processes forming a cycle.
//  clock : rising-edge clock
//  reset : asynchronous active-high reset
//  bus   : slave side of dataflow_deadlock_tracer_if (enable/clear/blocked/wait_on in,
//          deadlock/cycle_mask/origin/state out)
module dataflow_deadlock_tracer #(
    parameter int unsigned N_PROC       = 3,
    parameter int unsigned STALL_CYCLES = 64,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                        clock,
    input  logic                        reset,
    dataflow_deadlock_tracer_if.slave   bus
);
    localparam int unsigned ID_W = (N_PROC > 1) ? $clog2(N_PROC) : 1;
    localparam int unsigned W_W  = N_PROC * N_PROC;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WATCH  = 3'd1,
        TRACE  = 3'd2,
        CLOSE  = 3'd3,
        REPORT = 3'd4
    } state_t;

    state_t              state_q,      state_n;
    logic [N_PROC-1:0]   snap_b_q,     snap_b_n;
    logic [W_W-1:0]      snap_w_q,     snap_w_n;
    logic [CNT_W-1:0]    cnt_q,        cnt_n;
    logic [ID_W-1:0]     cur_q,        cur_n;
    logic [ID_W-1:0]     org_q,        org_n;
    logic [N_PROC-1:0]   visited_q,    visited_n;
    logic [N_PROC-1:0]   mask_q,       mask_n;
    logic                deadlock_q,   deadlock_n;
    logic [N_PROC-1:0]   cycle_mask_q, cycle_mask_n;
    logic [ID_W-1:0]     origin_q,     origin_n;

    logic [N_PROC-1:0]   cur_row;
    logic [N_PROC-1:0]   nxt_row;
    logic                has_succ;
    logic [ID_W-1:0]     nxt;
    logic [ID_W-1:0]     succ_nxt;

    // Wait-for row of process i taken from the snapshot.
    function automatic logic [N_PROC-1:0] row_of(input logic [ID_W-1:0] i, input logic [W_W-1:0] w);
        logic [W_W-1:0] s;
        s = w >> (int'(i) * N_PROC);
        return s[N_PROC-1:0];
    endfunction

    // Index of the lowest set bit; 0 when none is set.
    function automatic logic [ID_W-1:0] lowest(input logic [N_PROC-1:0] v);
        logic [ID_W-1:0] r;
        r = '0;
        for (int j = N_PROC - 1; j >= 0; j--) begin
            if (v[j]) r = ID_W'(j);
        end
        return r;
    endfunction

    // Graph lookups: successor of cur, and successor of that successor (used on cycle closure).
    always_comb begin
        cur_row  = row_of(cur_q, snap_w_q);
        has_succ = |cur_row;
        nxt      = lowest(cur_row);
        nxt_row  = row_of(nxt, snap_w_q);
        succ_nxt = lowest(nxt_row);
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            snap_b_q     <= '0;
            snap_w_q     <= '0;
            cnt_q        <= '0;
            cur_q        <= '0;
            org_q        <= '0;
            visited_q    <= '0;
            mask_q       <= '0;
            deadlock_q   <= 1'b0;
            cycle_mask_q <= '0;
            origin_q     <= '0;
        end else begin
            state_q      <= state_n;
            snap_b_q     <= snap_b_n;
            snap_w_q     <= snap_w_n;
            cnt_q        <= cnt_n;
            cur_q        <= cur_n;
            org_q        <= org_n;
            visited_q    <= visited_n;
            mask_q       <= mask_n;
            deadlock_q   <= deadlock_n;
            cycle_mask_q <= cycle_mask_n;
            origin_q     <= origin_n;
        end
    end

    // Next-state and report logic.
    always_comb begin
        state_n      = state_q;
        snap_b_n     = snap_b_q;
        snap_w_n     = snap_w_q;
        cnt_n        = cnt_q;
        cur_n        = cur_q;
        org_n        = org_q;
        visited_n    = visited_q;
        mask_n       = mask_q;
        deadlock_n   = deadlock_q;
        cycle_mask_n = cycle_mask_q;
        origin_n     = origin_q;

        if (bus.clear) begin
            state_n      = IDLE;
            deadlock_n   = 1'b0;
            cycle_mask_n = '0;
            origin_n     = '0;
        end else if (!bus.enable && state_q != REPORT) begin
            state_n = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|bus.blocked) begin
                        state_n  = WATCH;
                        snap_b_n = bus.blocked;
                        snap_w_n = bus.wait_on;
                        cnt_n    = CNT_W'(1);
                    end
                end
                WATCH: begin
                    if (bus.blocked == '0) begin
                        state_n = IDLE;
                    end else if (bus.blocked != snap_b_q || bus.wait_on != snap_w_q) begin
                        snap_b_n = bus.blocked;
                        snap_w_n = bus.wait_on;
                        cnt_n    = CNT_W'(1);
                    end else if (cnt_q == CNT_W'(STALL_CYCLES)) begin
                        state_n   = TRACE;
                        cur_n     = lowest(snap_b_q);
                        visited_n = N_PROC'(1) << lowest(snap_b_q);
                    end else if (cnt_q != '1) begin
                        cnt_n = cnt_q + CNT_W'(1);
                    end
                end
                TRACE, CLOSE: begin
                    if (bus.blocked != snap_b_q) begin
                        // Stall pattern moved under us: restart the stability window.
                        state_n  = WATCH;
                        snap_b_n = bus.blocked;
                        snap_w_n = bus.wait_on;
                        cnt_n    = CNT_W'(1);
                    end else if (state_q == TRACE) begin
                        if (!has_succ || !snap_b_q[nxt]) begin
                            state_n = WATCH;
                            cnt_n   = '0;
                        end else if (visited_q[nxt]) begin
                            // First revisit is the cycle entry; tail nodes are excluded from here on.
                            state_n = CLOSE;
                            org_n   = nxt;
                            mask_n  = N_PROC'(1) << nxt;
                            cur_n   = succ_nxt;
                        end else begin
                            visited_n = visited_q | (N_PROC'(1) << nxt);
                            cur_n     = nxt;
                        end
                    end else begin
                        if (cur_q == org_q) begin
                            state_n      = REPORT;
                            deadlock_n   = 1'b1;
                            cycle_mask_n = mask_q;
                            origin_n     = org_q;
                        end else begin
                            mask_n = mask_q | (N_PROC'(1) << cur_q);
                            cur_n  = nxt;
                        end
                    end
                end
                REPORT: begin
                    state_n = REPORT;
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    assign bus.deadlock   = deadlock_q;
    assign bus.cycle_mask = cycle_mask_q;
    assign bus.origin     = origin_q;
    assign bus.state      = state_q;
endmodule

// File: tb/tb_dataflow_deadlock_tracer.sv
// Directed bench for dataflow_deadlock_tracer: a 3-process instance for the main scenarios and an
// 8-process ring instance; expected values are hand-computed from the trace algorithm.
module tb_dataflow_deadlock_tracer;
    logic clock;
    logic reset;

    int n_checks;
    int n_errors;

    dataflow_deadlock_tracer_if #(.N_PROC(3)) bus3 ();
    dataflow_deadlock_tracer_if #(.N_PROC(8)) bus8 ();

    dataflow_deadlock_tracer #(.N_PROC(3), .STALL_CYCLES(64), .CNT_W(16)) u3 (
        .clock (clock),
        .reset (reset),
        .bus   (bus3.slave)
    );

    dataflow_deadlock_tracer #(.N_PROC(8), .STALL_CYCLES(64), .CNT_W(16)) u8 (
        .clock (clock),
        .reset (reset),
        .bus   (bus8.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; sample point sits 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive3(input logic en, input logic [2:0] b, input logic [8:0] w);
        bus3.enable  = en;
        bus3.blocked = b;
        bus3.wait_on = w;
    endtask

    task automatic pulse_clear3();
        bus3.clear = 1'b1;
        tick();
        bus3.clear = 1'b0;
    endtask

    int lat;
    int entries;
    logic seen_dl;
    logic seen_trace;
    logic [2:0] prev_state;
    logic [63:0] ring;

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b1;
        bus3.clear = 1'b0;
        drive3(1'b0, 3'b000, 9'h000);
        bus8.clear = 1'b0;
        bus8.enable = 1'b0;
        bus8.blocked = '0;
        bus8.wait_on = '0;
        #12;
        check("rst_state", 32'(bus3.state), 32'd0);
        check("rst_deadlock", 32'(bus3.deadlock), 32'd0);
        check("rst_mask", 32'(bus3.cycle_mask), 32'd0);
        check("rst_origin", 32'(bus3.origin), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        tick();

        // 1: ring 0->1->2->0
        drive3(1'b1, 3'b111, 9'h062);
        lat = 0;
        while (!bus3.deadlock && lat < 200) begin
            tick();
            lat++;
        end
        check("t1_found", 32'(bus3.deadlock), 32'd1);
        check("t1_latency_le71", 32'(lat <= 71), 32'd1);
        check("t1_mask", 32'(bus3.cycle_mask), 32'h7);
        check("t1_origin", 32'(bus3.origin), 32'd0);
        check("t1_state", 32'(bus3.state), 32'd4);
        bus3.enable = 1'b0;
        repeat (3) tick();
        check("t1_hold_dis", 32'(bus3.deadlock), 32'd1);
        pulse_clear3();
        check("t1_clear_state", 32'(bus3.state), 32'd0);
        check("t1_clear_dl", 32'(bus3.deadlock), 32'd0);

        // 2: tail 0 feeding cycle 1<->2
        drive3(1'b1, 3'b111, 9'h0A2);
        lat = 0;
        while (!bus3.deadlock && lat < 200) begin
            tick();
            lat++;
        end
        check("t2_found", 32'(bus3.deadlock), 32'd1);
        check("t2_mask", 32'(bus3.cycle_mask), 32'h6);
        check("t2_origin", 32'(bus3.origin), 32'd1);
        drive3(1'b1, 3'b000, 9'h000);
        pulse_clear3();

        // 3: transient cyclic stall for 63 cycles
        drive3(1'b1, 3'b111, 9'h062);
        seen_trace = 1'b0;
        seen_dl = 1'b0;
        for (int i = 0; i < 63; i++) begin
            tick();
            if (bus3.state == 3'd2) seen_trace = 1'b1;
            if (bus3.deadlock) seen_dl = 1'b1;
        end
        drive3(1'b1, 3'b000, 9'h000);
        tick();
        check("t3_no_trace", 32'(seen_trace), 32'd0);
        check("t3_no_dl", 32'(seen_dl | bus3.deadlock), 32'd0);
        check("t3_idle", 32'(bus3.state), 32'd0);

        // 4: open chain 0->1->2, TRACE re-armed every 68 cycles
        drive3(1'b1, 3'b111, 9'h022);
        entries = 0;
        seen_dl = 1'b0;
        prev_state = bus3.state;
        for (int i = 0; i < 500; i++) begin
            tick();
            if (bus3.state == 3'd2 && prev_state != 3'd2) entries++;
            if (bus3.deadlock) seen_dl = 1'b1;
            prev_state = bus3.state;
        end
        check("t4_no_dl", 32'(seen_dl), 32'd0);
        check("t4_trace_entries", 32'(entries), 32'd7);
        drive3(1'b1, 3'b000, 9'h000);
        pulse_clear3();

        // 5: self-loop on process 2
        drive3(1'b1, 3'b100, 9'h100);
        lat = 0;
        while (!bus3.deadlock && lat < 200) begin
            tick();
            lat++;
        end
        check("t5_found", 32'(bus3.deadlock), 32'd1);
        check("t5_mask", 32'(bus3.cycle_mask), 32'h4);
        check("t5_origin", 32'(bus3.origin), 32'd2);
        pulse_clear3();
        check("t5_clr_state", 32'(bus3.state), 32'd0);
        check("t5_clr_dl", 32'(bus3.deadlock), 32'd0);
        check("t5_clr_mask", 32'(bus3.cycle_mask), 32'd0);
        check("t5_clr_origin", 32'(bus3.origin), 32'd0);
        drive3(1'b1, 3'b000, 9'h000);
        tick();

        // 6a: async reset in the middle of TRACE
        drive3(1'b1, 3'b111, 9'h062);
        repeat (66) tick();
        check("t6_in_trace", 32'(bus3.state), 32'd2);
        #2;
        reset = 1'b1;
        #1;
        check("t6_rst_state", 32'(bus3.state), 32'd0);
        check("t6_rst_dl", 32'(bus3.deadlock), 32'd0);
        drive3(1'b0, 3'b000, 9'h000);
        @(negedge clock);
        reset = 1'b0;
        tick();

        // 6b: 8-process ring i -> (i+1) mod 8
        ring = '0;
        for (int i = 0; i < 8; i++) ring[i*8 + ((i + 1) % 8)] = 1'b1;
        bus8.wait_on = ring;
        bus8.blocked = 8'hFF;
        bus8.enable = 1'b1;
        lat = 0;
        while (!bus8.deadlock && lat < 300) begin
            tick();
            lat++;
        end
        check("t6_ring_found", 32'(bus8.deadlock), 32'd1);
        check("t6_ring_latency_le81", 32'(lat <= 81), 32'd1);
        check("t6_ring_mask", 32'(bus8.cycle_mask), 32'hFF);
        check("t6_ring_origin", 32'(bus8.origin), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
